hazard_control: RTL and testbench

Pipeline hazard controller for the 5-stage CPU: consumes the ID/EX pipeline register outputs and the IF/ID source addresses, and drives the stall, bubble, hold and flush controls back into the PC, IF/ID and ID/EX registers. It detects load-use hazards, stretches stalls for multi-cycle loads, freezes the front end while data memory is busy, and squashes wrong-path instructions on a taken branch. A registered FSM holds the multi-cycle state; the control outputs are Mealy and valid in the same cycle as the hazard.

---
 rtl/hazard_control.sv | 109 ++++++++++
 tb/tb_hazard_control.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Load-use / memory-busy / branch-flush hazard controller for the 5-stage pipeline.
// Optional `HAZARD_STATS_EN adds a saturating StallCount output.
module hazard_control #(
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ID_EX_M,
  input  logic [4:0] ID_EX_RtAddr,
  input  logic [4:0] IF_ID_RsAddr,
  input  logic [4:0] IF_ID_RtAddr,
  input  logic       IF_ID_UsesRt,
  input  logic       BranchTaken,
  input  logic       MemBusy,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       ID_EX_Hold,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] StallCount
`endif
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] LDSTALL = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  logic [1:0] state, state_n, eff_state;
  logic [3:0] cnt, cnt_n;
  logic       hz;
  logic       unused_store;

  // Stores never create a load-use hazard.
  assign unused_store = ID_EX_M[0];

  assign hz = ID_EX_M[1] && (ID_EX_RtAddr != 5'd0) &&
              ((ID_EX_RtAddr == IF_ID_RsAddr) ||
               (IF_ID_UsesRt && (ID_EX_RtAddr == IF_ID_RtAddr)));

  // MEMWAIT resumes whichever stall state was interrupted, recovered from cnt.
  always_comb begin
    eff_state = state;
    if (state == MEMWAIT)
      eff_state = (cnt != 4'd0) ? LDSTALL : RUN;
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    ID_EX_Hold   = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    state_n      = eff_state;
    cnt_n        = cnt;
    if (rst) begin
      state_n = RUN;
      cnt_n   = '0;
    end else if (MemBusy) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Hold  = 1'b1;
      state_n     = MEMWAIT;
    end else if (BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      state_n     = RUN;
      cnt_n       = '0;
    end else if (eff_state == LDSTALL) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      cnt_n        = cnt - 4'd1;
      if (cnt == 4'd1)
        state_n = RUN;
    end else if (hz) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      if (LOAD_STALL > 1) begin
        state_n = LDSTALL;
        cnt_n   = 4'(LOAD_STALL - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      StallCount <= '0;
    else if (!PCWrite && (StallCount != 16'hFFFF))
      StallCount <= StallCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: two instances (LOAD_STALL=1 and 3) share inputs.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ID_EX_M;
  logic [4:0] ID_EX_RtAddr, IF_ID_RsAddr, IF_ID_RtAddr;
  logic       IF_ID_UsesRt, BranchTaken, MemBusy;

  logic pcw1, ifw1, bub1, hold1, iff1, idf1;
  logic pcw3, ifw3, bub3, hold3, iff3, idf3;
  logic [5:0] o1, o3;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, sc3;
`endif

  int checks = 0;
  int errors = 0;

  // {PCWrite, IF_ID_Write, Bubble, Hold, IF_ID_Flush, ID_EX_Flush}
  localparam logic [5:0] RUNO  = 6'b110000;
  localparam logic [5:0] STALL = 6'b001000;
  localparam logic [5:0] HOLD  = 6'b000100;
  localparam logic [5:0] FLUSH = 6'b110011;

  always #5 clk = ~clk;

  assign o1 = {pcw1, ifw1, bub1, hold1, iff1, idf1};
  assign o3 = {pcw3, ifw3, bub3, hold3, iff3, idf3};

  hazard_control #(.LOAD_STALL(1)) u1 (
    .clk(clk), .rst(rst), .ID_EX_M(ID_EX_M), .ID_EX_RtAddr(ID_EX_RtAddr),
    .IF_ID_RsAddr(IF_ID_RsAddr), .IF_ID_RtAddr(IF_ID_RtAddr),
    .IF_ID_UsesRt(IF_ID_UsesRt), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .PCWrite(pcw1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1), .ID_EX_Hold(hold1),
    .IF_ID_Flush(iff1), .ID_EX_Flush(idf1)
`ifdef HAZARD_STATS_EN
    , .StallCount(sc1)
`endif
  );

  hazard_control #(.LOAD_STALL(3)) u3 (
    .clk(clk), .rst(rst), .ID_EX_M(ID_EX_M), .ID_EX_RtAddr(ID_EX_RtAddr),
    .IF_ID_RsAddr(IF_ID_RsAddr), .IF_ID_RtAddr(IF_ID_RtAddr),
    .IF_ID_UsesRt(IF_ID_UsesRt), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .PCWrite(pcw3), .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3), .ID_EX_Hold(hold3),
    .IF_ID_Flush(iff3), .ID_EX_Flush(idf3)
`ifdef HAZARD_STATS_EN
    , .StallCount(sc3)
`endif
  );

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    rst = 1'b0; ID_EX_M = 2'b00; ID_EX_RtAddr = 5'd0; IF_ID_RsAddr = 5'd0;
    IF_ID_RtAddr = 5'd0; IF_ID_UsesRt = 1'b0; BranchTaken = 1'b0; MemBusy = 1'b0;
  endtask

  task automatic load_hz();
    clear_in();
    ID_EX_M = 2'b10; ID_EX_RtAddr = 5'd5; IF_ID_RsAddr = 5'd5;
  endtask

  // Advance one clock and settle mid-cycle before the next checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    // Reset dominates even with hazard, MemBusy and BranchTaken present.
    load_hz(); rst = 1'b1; MemBusy = 1'b1; BranchTaken = 1'b1;
    #3;
    check("rst_u1", o1, RUNO);
    check("rst_u3", o3, RUNO);
    tick(); tick();
`ifdef HAZARD_STATS_EN
    check16("sc_after_rst", sc3, 16'd0);
`endif

    // Load-use hazard on Rs.
    load_hz(); #3;
    check("hz_u1", o1, STALL);
    check("hz_u3_s1", o3, STALL);
    tick(); clear_in(); #3;
    check("hz_u1_after", o1, RUNO);
    check("hz_u3_s2", o3, STALL);
    tick(); #3;
    check("hz_u3_s3", o3, STALL);
    tick(); #3;
    check("hz_u3_done", o3, RUNO);
    check("hz_u1_idle", o1, RUNO);
`ifdef HAZARD_STATS_EN
    check16("sc_u3_three", sc3, 16'd3);
    check16("sc_u1_one", sc1, 16'd1);
`endif

    // No-stall cases: r0 destination, Rt match without UsesRt, store.
    clear_in(); ID_EX_M = 2'b10; #3;
    check("r0_nostall", o3, RUNO);
    clear_in(); ID_EX_M = 2'b10; ID_EX_RtAddr = 5'd7; IF_ID_RtAddr = 5'd7;
    IF_ID_RsAddr = 5'd3; #3;
    check("rt_unused_nostall", o3, RUNO);
    ID_EX_M = 2'b01; IF_ID_UsesRt = 1'b1; #3;
    check("store_nostall", o3, RUNO);
    ID_EX_M = 2'b10; #3;
    check("rt_used_u1", o1, STALL);
    check("rt_used_u3", o3, STALL);

    // Branch in the second stall cycle aborts the stall.
    tick(); clear_in(); BranchTaken = 1'b1; #3;
    check("br_u3_flush", o3, FLUSH);
    check("br_u1_flush", o1, FLUSH);
    tick(); clear_in(); #3;
    check("br_u3_after", o3, RUNO);

    // MemBusy while LDSTALL holds cnt=1.
    load_hz(); tick(); clear_in(); #3;
    check("mb_u3_s2", o3, STALL);
    tick(); MemBusy = 1'b1; #3;
    check("mb_u3_hold1", o3, HOLD);
    check("mb_u1_hold1", o1, HOLD);
    tick(); #3;
    check("mb_u3_hold2", o3, HOLD);
    tick(); MemBusy = 1'b0; #3;
    check("mb_u3_resume", o3, STALL);
    check("mb_u1_resume", o1, RUNO);
    tick(); #3;
    check("mb_u3_done", o3, RUNO);

    // MemBusy and BranchTaken together: hold only, flush once MemBusy drops.
    MemBusy = 1'b1; BranchTaken = 1'b1; #3;
    check("mbbr_hold", o3, HOLD);
    tick(); MemBusy = 1'b0; #3;
    check("mbbr_flush", o3, FLUSH);
    tick(); clear_in(); #3;
    check("mbbr_after", o3, RUNO);

    // Reset in the middle of a stall.
    load_hz(); tick(); clear_in(); rst = 1'b1; #3;
    check("rst_mid_out", o3, RUNO);
    tick(); rst = 1'b0; #3;
    check("rst_mid_run", o3, RUNO);
`ifdef HAZARD_STATS_EN
    check16("sc_rst_mid", sc3, 16'd0);
    load_hz(); tick(); clear_in(); #3;
    check16("sc_incr", sc3, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
